// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants and S-box lookups
package aes_pkg;

  localparam int KEY_ADDR_W = 4;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/sub_bytes.sv
// rtl/sub_bytes.sv - registered forward SubBytes with clock enable
module sub_bytes
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  logic [127:0] data_q;
  logic [127:0] data_d;

  always_comb begin
    data_d = '0;
    for (int k = 0; k < 16; k++) begin
      data_d[127-8*k -: 8] = sbox(data_i[127-8*k -: 8]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/enc_round_last.sv
// rtl/enc_round_last.sv - AES-128 final encryption round (SubBytes, ShiftRows, AddRoundKey)
// Two-stage valid/ready pipeline; round key captured from the broadcast key bus.
module enc_round_last
  import aes_pkg::*;
#(
  parameter logic [KEY_ADDR_W-1:0] ADDRESS = 4'd10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [127:0]          rkey,
  input  logic [KEY_ADDR_W-1:0] addr,
  input  logic                  key_we,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [127:0]          din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [127:0]          dout
);

  logic [127:0] key_q, key_d;
  logic         key_loaded_q, key_loaded_d;
  logic         s1_valid_q, s1_valid_d;
  logic         out_valid_q, out_valid_d;
  logic [127:0] dout_q, dout_d;
  logic [127:0] s1_data;
  logic [127:0] sr_state;
  logic         s1_en, s2_en;

  assign s2_en    = !out_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = key_loaded_q && s1_en;

  // Stage 1 loads on every enabled edge; s1_valid marks whether the data is real.
  sub_bytes u_sub_bytes (
    .clk    (clk),
    .rst    (rst),
    .en_i   (s1_en),
    .data_i (din),
    .data_o (s1_data)
  );

  // Row r of the column-major state rotates left by r bytes.
  always_comb begin
    sr_state = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_state[127-8*(4*c+r) -: 8] = s1_data[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  always_comb begin
    key_d        = key_q;
    key_loaded_d = key_loaded_q;
    s1_valid_d   = s1_valid_q;
    out_valid_d  = out_valid_q;
    dout_d       = dout_q;
    if (key_we && addr == ADDRESS) begin
      key_d        = rkey;
      key_loaded_d = 1'b1;
    end
    if (s1_en) begin
      s1_valid_d = in_valid && in_ready;
    end
    // key_q here is the pre-write value, so a same-edge key write affects only later blocks.
    if (s2_en) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        dout_d = sr_state ^ key_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q        <= '0;
      key_loaded_q <= 1'b0;
      s1_valid_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      dout_q       <= '0;
    end else begin
      key_q        <= key_d;
      key_loaded_q <= key_loaded_d;
      s1_valid_q   <= s1_valid_d;
      out_valid_q  <= out_valid_d;
      dout_q       <= dout_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;

endmodule

// File: tb/tb_enc_round_last.sv
// tb/tb_enc_round_last.sv - self-checking bench for enc_round_last
module tb_enc_round_last;

  localparam logic [127:0] FIPS_IN  = 128'heb40f21e592e38848ba113e71bc342d2;
  localparam logic [127:0] FIPS_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_OUT = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] rkey;
  logic [3:0]   addr;
  logic         key_we;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] din;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dout;

  always #5 clk = ~clk;

  enc_round_last dut (
    .clk       (clk),
    .rst       (rst),
    .rkey      (rkey),
    .addr      (addr),
    .key_we    (key_we),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout)
  );

  int           n_pass = 0;
  int           n_total = 0;
  int           n_acc = 0;
  int           n_out = 0;
  int           cyc = 0;
  int           first_out = -1;
  int           last_out = -1;
  logic [7:0]   sbox_ref [256];
  logic [127:0] mkey = '0;
  logic [127:0] exp_q [$];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] w;
    w = {b, b} << n;
    return w[15:8];
  endfunction

  // S-box from first principles: GF(2^8) inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    if (x == 8'h00) inv = 8'h00;
    else repeat (254) inv = gmul(inv, x);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key);
    logic [7:0]   m [4][4];
    logic [7:0]   t;
    logic [127:0] res;
    for (int k = 0; k < 16; k++) m[k%4][k/4] = sbox_ref[st[127-8*k -: 8]];
    for (int r = 0; r < 4; r++) begin
      repeat (r) begin
        t = m[r][0]; m[r][0] = m[r][1]; m[r][1] = m[r][2]; m[r][2] = m[r][3]; m[r][3] = t;
      end
    end
    res = '0;
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = m[k%4][k/4];
    return res ^ key;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step(input logic v, input logic [127:0] d, input logic ordy,
                      input logic kwe, input logic [3:0] ka, input logic [127:0] kv);
    @(negedge clk);
    in_valid = v; din = d; out_ready = ordy; key_we = kwe; addr = ka; rkey = kv;
    if (kwe && ka == 4'd10) mkey = kv;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 128'(out_valid), 128'd0);
      else chk("dout", dout, exp_q.pop_front());
      n_out++;
      last_out = cyc;
      if (first_out < 0) first_out = cyc;
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_round(d, mkey));
      n_acc++;
    end
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, ordy, 1'b0, 4'd0, '0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) idle(1'b1);
    chk(tag, 128'(exp_q.size()), 128'd0);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] blk [4];
    logic [127:0] k2;
    int na, acc0, out0;

    rst = 1'b0; rkey = '0; addr = '0; key_we = 1'b0;
    in_valid = 1'b0; din = '0; out_ready = 1'b0;
    for (int x = 0; x < 256; x++) sbox_ref[x] = sbox_calc(8'(x));

    @(negedge clk); #1;
    chk("reset_out_valid", 128'(out_valid), 128'd0);
    chk("reset_dout", dout, 128'd0);
    chk("reset_in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    rst = 1'b1;

    // Address filter then FIPS-197 round 10
    step(1'b1, FIPS_IN, 1'b1, 1'b1, 4'd9, ~FIPS_KEY);
    chk("filter_in_ready0", 128'(in_ready), 128'd0);
    step(1'b1, FIPS_IN, 1'b1, 1'b0, 4'd0, '0);
    chk("filter_in_ready1", 128'(in_ready), 128'd0);
    chk("filter_no_accept", 128'(n_acc), 128'd0);
    step(1'b0, '0, 1'b1, 1'b1, 4'd10, FIPS_KEY);
    step(1'b1, FIPS_IN, 1'b1, 1'b0, 4'd0, '0);
    chk("fips_in_ready", 128'(in_ready), 128'd1);
    idle(1'b1);
    chk("fips_latency_not_yet", 128'(out_valid), 128'd0);
    idle(1'b1);
    chk("fips_out_valid", 128'(out_valid), 128'd1);
    chk("fips_dout", dout, FIPS_OUT);
    drain("fips_drain");

    // Back-to-back throughput
    cyc = 0; first_out = -1; last_out = -1; out0 = n_out;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, rand128(), 1'b1, 1'b0, 4'd0, '0);
      chk("tp_in_ready", 128'(in_ready), 128'd1);
    end
    drain("tp_drain");
    chk("tp_count", 128'(n_out - out0), 128'd16);
    chk("tp_first_out", 128'(first_out), 128'd2);
    chk("tp_span", 128'(last_out - first_out), 128'd15);

    // Backpressure: 5 stalled cycles
    for (int i = 0; i < 4; i++) blk[i] = rand128();
    na = 0; out0 = n_out;
    for (int i = 0; i < 5; i++) begin
      acc0 = n_acc;
      step(na < 4, blk[na%4], 1'b0, 1'b0, 4'd0, '0);
      if (n_acc != acc0) na++;
    end
    chk("bp_accepted", 128'(na), 128'd2);
    chk("bp_in_ready", 128'(in_ready), 128'd0);
    chk("bp_out_valid", 128'(out_valid), 128'd1);
    chk("bp_hold", dout, exp_q[0]);
    for (int i = 0; i < 20 && na < 4; i++) begin
      acc0 = n_acc;
      step(1'b1, blk[na], 1'b1, 1'b0, 4'd0, '0);
      if (n_acc != acc0) na++;
    end
    drain("bp_drain");
    chk("bp_count", 128'(n_out - out0), 128'd4);

    // Key change on the edge block A enters stage 2
    k2 = rand128();
    step(1'b1, rand128(), 1'b1, 1'b0, 4'd0, '0);
    step(1'b1, rand128(), 1'b1, 1'b1, 4'd10, k2);
    drain("keychg_drain");

    // Reset mid-stream
    step(1'b1, rand128(), 1'b0, 1'b0, 4'd0, '0);
    idle(1'b0);
    idle(1'b0);
    chk("pre_reset_out_valid", 128'(out_valid), 128'd1);
    #1 rst = 1'b0;
    #1;
    chk("async_reset_out_valid", 128'(out_valid), 128'd0);
    chk("async_reset_dout", dout, 128'd0);
    chk("async_reset_in_ready", 128'(in_ready), 128'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    acc0 = n_acc;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, rand128(), 1'b1, 1'b0, 4'd0, '0);
      chk("post_reset_in_ready", 128'(in_ready), 128'd0);
    end
    chk("post_reset_no_accept", 128'(n_acc - acc0), 128'd0);
    step(1'b0, '0, 1'b1, 1'b1, 4'd10, FIPS_KEY);
    step(1'b1, FIPS_IN, 1'b1, 1'b0, 4'd0, '0);
    idle(1'b1);
    idle(1'b1);
    chk("reload_dout", dout, FIPS_OUT);
    drain("reload_drain");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
